// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encoding, Nk/Nr lookups and the forward S-box.
package aes_pkg;

   typedef enum logic [1:0] {
      KeyMode128  = 2'b00,
      KeyMode192  = 2'b01,
      KeyMode256  = 2'b10,
      KeyModeRsvd = 2'b11
   } key_mode_e;

   // Row-major, entry 0 in the MSBs.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [3:0] nk_of(input logic [1:0] mode);
      case (mode)
         KeyMode128: return 4'd4;
         KeyMode192: return 4'd6;
         default:    return 4'd8;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] mode);
      case (mode)
         KeyMode128: return 4'd10;
         KeyMode192: return 4'd12;
         default:    return 4'd14;
      endcase
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel byte S-box lookups, purely combinational.
module aes_sbox_word
   import aes_pkg::*;
(
   input  logic [31:0] in_word,
   output logic [31:0] sub_word
);

   assign sub_word = {sbox(in_word[31:24]), sbox(in_word[23:16]),
                      sbox(in_word[15:8]),  sbox(in_word[7:0])};

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES key expansion: one schedule word per cycle into a register store,
// with a registered round-key read port.
module aes_key_sched
   import aes_pkg::*;
#(
   parameter int unsigned WORD_LEN    = 32,
   parameter int unsigned MAX_KEY_LEN = 256,
   parameter int unsigned MAX_ROUNDS  = 14
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [MAX_KEY_LEN-1:0]  Secret_key,
   input  logic [1:0]              key_mode,
   input  logic                    valid_in,
   output logic                    ready,
   output logic                    valid_out,
   output logic                    key_valid,
   output logic                    err,
   output logic [3:0]              nr,
   input  logic [3:0]              rk_addr,
   output logic [4*WORD_LEN-1:0]   rk_data
);

   localparam int unsigned DEPTH     = 4 * (MAX_ROUNDS + 1);
   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned KEY_WORDS = MAX_KEY_LEN / WORD_LEN;

   typedef enum logic {StIdle, StExpand} state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         idx_q;
   logic [3:0]            phase_q;  // i mod Nk for the word being written
   logic [3:0]            nk_q;
   logic [3:0]            nr_q;
   logic [7:0]            rcon_q;
   logic                  key_valid_q;
   logic                  valid_out_q;
   logic                  err_q;
   logic [4*WORD_LEN-1:0] rk_data_q;
   logic [WORD_LEN-1:0]   w_q [DEPTH];

   logic [WORD_LEN-1:0] prev_word, far_word, sbox_in, sbox_out, temp_word, new_word;
   logic [AW-1:0]       last_idx, rk_base;
   logic                accept, last_word, rk_ok;

   assign accept    = (state_q == StIdle) && valid_in && (key_mode != KeyModeRsvd);
   assign last_idx  = AW'({nr_q, 2'b11});
   assign last_word = (idx_q == last_idx);
   assign prev_word = w_q[idx_q - 1'b1];
   assign far_word  = w_q[idx_q - AW'(nk_q)];
   assign sbox_in   = (phase_q == 4'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

   aes_sbox_word u_sbox_word (
      .in_word  (sbox_in),
      .sub_word (sbox_out)
   );

   always_comb begin
      temp_word = prev_word;
      if (phase_q == 4'd0) begin
         temp_word = sbox_out ^ {rcon_q, 24'h0};
      end else if (nk_q == 4'd8 && phase_q == 4'd4) begin
         temp_word = sbox_out;
      end
      new_word = far_word ^ temp_word;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (accept) state_d = StExpand;
         StExpand: if (last_word) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         phase_q     <= 4'd0;
         nk_q        <= 4'd4;
         nr_q        <= 4'd10;
         rcon_q      <= 8'h01;
         key_valid_q <= 1'b0;
         valid_out_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_out_q <= 1'b0;
         err_q       <= (state_q == StIdle) && valid_in && (key_mode == KeyModeRsvd);
         if (accept) begin
            nk_q        <= nk_of(key_mode);
            nr_q        <= nr_of(key_mode);
            idx_q       <= AW'(nk_of(key_mode));
            phase_q     <= 4'd0;
            rcon_q      <= 8'h01;
            key_valid_q <= 1'b0;
         end else if (state_q == StExpand) begin
            idx_q   <= idx_q + 1'b1;
            phase_q <= (phase_q == nk_q - 4'd1) ? 4'd0 : phase_q + 4'd1;
            if (phase_q == 4'd0) begin
               rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            if (last_word) begin
               valid_out_q <= 1'b1;
               key_valid_q <= 1'b1;
            end
         end
      end
   end

   // Unused key words beyond Nk are overwritten during expansion.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int j = 0; j < KEY_WORDS; j++) begin
            w_q[j] <= Secret_key[MAX_KEY_LEN-1-WORD_LEN*j -: WORD_LEN];
         end
      end else if (state_q == StExpand) begin
         w_q[idx_q] <= new_word;
      end
   end

   assign rk_base = AW'({rk_addr, 2'b00});
   assign rk_ok   = key_valid_q && (rk_addr <= nr_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         rk_data_q <= '0;
      end else if (rk_ok) begin
         rk_data_q <= {w_q[rk_base], w_q[rk_base + AW'(1)],
                       w_q[rk_base + AW'(2)], w_q[rk_base + AW'(3)]};
      end else begin
         rk_data_q <= '0;
      end
   end

   assign ready     = (state_q == StIdle);
   assign valid_out = valid_out_q;
   assign key_valid = key_valid_q;
   assign err       = err_q;
   assign nr        = nr_q;
   assign rk_data   = rk_data_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench: FIPS-197 key expansion model built from GF(2^8) arithmetic,
// compared against the DUT every cycle, plus known-answer vectors.
module tb_aes_key_sched;

   logic         clk = 1'b0;
   logic         reset;
   logic [255:0] Secret_key;
   logic [1:0]   key_mode;
   logic         valid_in;
   logic         ready, valid_out, key_valid, err;
   logic [3:0]   nr;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;

   aes_key_sched dut (
      .clk        (clk),
      .reset      (reset),
      .Secret_key (Secret_key),
      .key_mode   (key_mode),
      .valid_in   (valid_in),
      .ready      (ready),
      .valid_out  (valid_out),
      .key_valid  (key_valid),
      .err        (err),
      .nr         (nr),
      .rk_addr    (rk_addr),
      .rk_data    (rk_data)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   bit          chk_en  = 1'b0;
   bit          rand_addr = 1'b0;

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                      64'h0};
   localparam logic [255:0] KEY256 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   // ---------------- reference model ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] v);
      return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
   endfunction

   function automatic logic [127:0] model_rk(input logic [255:0] key, input int nk, input int r);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      int          total = 4 * (nk + 7);
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < total; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk == 8 && i % 8 == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Transaction-level expectations, advanced on every clock edge.
   int           m_busy = 0;
   bit           m_kv = 1'b0, m_vo = 1'b0, m_err = 1'b0;
   int           m_nr = 10, m_nk = 4;
   logic [255:0] m_key = '0;
   logic [127:0] m_rk = '0;

   always @(posedge clk) begin
      logic [127:0] rk_next;
      rk_next = (m_kv && int'(rk_addr) <= m_nr) ? model_rk(m_key, m_nk, int'(rk_addr)) : '0;
      if (reset) begin
         m_busy = 0; m_kv = 1'b0; m_vo = 1'b0; m_err = 1'b0; m_nr = 10; rk_next = '0;
      end else begin
         m_vo  = 1'b0;
         m_err = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_vo = 1'b1;
               m_kv = 1'b1;
            end
         end else if (valid_in) begin
            if (key_mode == 2'b11) begin
               m_err = 1'b1;
            end else begin
               m_nk   = 4 + 2 * int'(key_mode);
               m_nr   = m_nk + 6;
               m_key  = Secret_key;
               m_kv   = 1'b0;
               m_busy = 4 * (m_nr + 1) - m_nk;
            end
         end
      end
      m_rk = rk_next;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready",     128'(ready),     128'(m_busy == 0));
         chk("valid_out", 128'(valid_out), 128'(m_vo));
         chk("key_valid", 128'(key_valid), 128'(m_kv));
         chk("err",       128'(err),       128'(m_err));
         chk("nr",        128'(nr),        128'(m_nr));
         chk("rk_data",   rk_data,         m_rk);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
      if (rand_addr) rk_addr = 4'($urandom_range(0, 15));
   endtask

   task automatic run(input logic [1:0] mode, input logic [255:0] key, input int exp_lat,
                      input string nm);
      int lat;
      for (int k = 0; k < 200 && !ready; k++) tick();
      key_mode   = mode;
      Secret_key = key;
      valid_in   = 1'b1;
      tick();
      valid_in = 1'b0;
      lat = 0;
      while (lat < 200 && !valid_out) begin
         tick();
         lat++;
      end
      chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
   endtask

   initial begin
      int vo_cnt;
      logic [255:0] rkey;
      reset = 1'b1; valid_in = 1'b0; key_mode = 2'b00; Secret_key = '0; rk_addr = 4'd0;
      build_sbox();

      chk("model aes128 rk10", model_rk(KEY128, 4, 10), RK128_10);
      chk("model aes192 rk12", model_rk(KEY192, 6, 12), RK192_12);
      chk("model aes256 rk14", model_rk(KEY256, 8, 14), RK256_14);

      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset ready", 128'(ready), 128'(1));
      chk("reset key_valid", 128'(key_valid), 128'(0));
      chk("reset nr", 128'(nr), 128'(10));
      chk("reset rk_data", rk_data, 128'(0));

      run(2'b00, KEY128, 40, "aes128");
      rk_addr = 4'd10; tick();
      chk("aes128 rk10", rk_data, RK128_10);

      run(2'b01, KEY192, 46, "aes192");
      chk("aes192 nr", 128'(nr), 128'(12));
      rk_addr = 4'd12; tick();
      chk("aes192 rk12", rk_data, RK192_12);

      run(2'b10, KEY256, 52, "aes256");
      rk_addr = 4'd14; tick();
      chk("aes256 rk14", rk_data, RK256_14);
      rk_addr = 4'd15; tick();
      chk("aes256 rk15", rk_data, 128'(0));

      // Reset in the middle of an AES-256 expansion.
      key_mode = 2'b10; Secret_key = KEY256; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      repeat (20) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset ready", 128'(ready), 128'(1));
      chk("midreset key_valid", 128'(key_valid), 128'(0));
      chk("midreset rk_data", rk_data, 128'(0));
      run(2'b00, KEY128, 40, "aes128 after reset");
      rk_addr = 4'd10; tick();
      chk("aes128 after reset rk10", rk_data, RK128_10);

      // Reserved mode request in IDLE.
      key_mode = 2'b11; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      chk("rsvd err", 128'(err), 128'(1));
      chk("rsvd ready", 128'(ready), 128'(1));
      chk("rsvd key_valid", 128'(key_valid), 128'(1));
      chk("rsvd nr", 128'(nr), 128'(10));
      tick();
      chk("rsvd err pulse", 128'(err), 128'(0));
      chk("rsvd rk10 kept", rk_data, RK128_10);

      // valid_in held high: one valid_out per run, immediate restart.
      rkey = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      key_mode = 2'b00; Secret_key = rkey; valid_in = 1'b1;
      tick();
      vo_cnt = 0;
      repeat (40) begin
         tick();
         if (valid_out) vo_cnt++;
      end
      chk("held valid_out count", 128'(vo_cnt), 128'(1));
      chk("held valid_out at 40", 128'(valid_out), 128'(1));
      tick();
      chk("restart accepted", 128'(ready), 128'(0));
      vo_cnt = 0;
      repeat (40) begin
         tick();
         if (valid_out) vo_cnt++;
      end
      valid_in = 1'b0;
      chk("restart valid_out", 128'(vo_cnt), 128'(1));

      // Random keys and modes, random round-key reads every cycle.
      rand_addr = 1'b1;
      for (int n = 0; n < 8; n++) begin
         key_mode   = 2'($urandom_range(0, 3));
         Secret_key = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
         valid_in   = 1'b1;
         tick();
         valid_in = 1'b0;
         for (int k = 0; k < 100 && !ready; k++) tick();
         repeat ($urandom_range(3, 20)) tick();
      end
      rand_addr = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, meaning key-schedule word width; only 32 is supported.
REQ-002 SHALL have parameter MAX_KEY_LEN, default 256, meaning widest supported key in bits; sets Secret_key width.
REQ-003 SHALL have parameter MAX_ROUNDS, default 14, meaning round count of the widest key; sets word store depth to 4*(MAX_ROUNDS+1).
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port Secret_key, input, MAX_KEY_LEN bits, cipher key left-justified: 128-bit key in [255:128], 192-bit key in [255:64].
REQ-007 SHALL have port key_mode, input, 2 bits, key length: 00=128, 01=192, 10=256, 11=reserved.
REQ-008 SHALL have port valid_in, input, 1 bit, start request.
REQ-009 SHALL have port ready, output, 1 bit, idle and able to accept valid_in.
REQ-010 SHALL have port valid_out, output, 1 bit, one-cycle expansion-complete pulse.
REQ-011 SHALL have port key_valid, output, 1 bit, a completed schedule is held in the store.
REQ-012 SHALL have port err, output, 1 bit, one-cycle pulse on a reserved-mode request.
REQ-013 SHALL have port nr, output, 4 bits, round count of the held schedule: 10, 12 or 14.
REQ-014 SHALL have port rk_addr, input, 4 bits, round-key index 0..nr.
REQ-015 SHALL have port rk_data, output, 128 bits, round key {w[4a], w[4a+1], w[4a+2], w[4a+3]}, with w[4a] in the MSBs.

Function
REQ-016 SHALL implement states IDLE and EXPAND; ready=1 only in IDLE.
REQ-017 SHALL accept a request on a clock edge where valid_in=1, ready=1 and key_mode is not 11; on acceptance it writes w[0..Nk-1] from Secret_key (Nk=4/6/8), latches nr (10/12/14), clears key_valid and enters EXPAND.
REQ-018 SHALL on a request with key_mode=11 in IDLE pulse err for one cycle and leave state, key_valid, nr and the store unchanged.
REQ-019 SHALL in EXPAND write exactly one word per cycle, for i = Nk up to 4*(nr+1)-1.
REQ-020 SHALL compute each word as w[i] = w[i-Nk] XOR t, where t is:
- SubWord(RotWord(w[i-1])) XOR {Rcon, 24'h0} when i mod Nk = 0;
- SubWord(w[i-1]) when Nk = 8 and i mod 8 = 4;
- w[i-1] otherwise.
REQ-021 SHALL generate Rcon iteratively: 01 on acceptance; multiply by x in GF(2^8) modulo 11B after each use (sequence 01,02,...,80,1B,36).
REQ-022 SHALL assert valid_out for exactly one cycle, in the cycle after the final word write, together with key_valid=1 and ready=1.
REQ-023 SHALL have accept-to-valid_out latency of 40/46/52 clock edges for 128/192/256.
REQ-024 SHALL ignore valid_in while in EXPAND; no request is queued.
REQ-025 SHALL register rk_data with 1-cycle latency from rk_addr.
REQ-026 SHALL drive rk_data=0 when key_valid=0 or rk_addr>nr.
REQ-027 SHALL accept a new request immediately after valid_out, in the valid_out cycle, and overwrite the store from w[0].

Reset
REQ-028 SHALL on reset, including mid-EXPAND, enter IDLE with ready=1, valid_out=0, key_valid=0, err=0, nr=10 and rk_data=0; store contents are don't-care.
REQ-029 SHALL give reset priority over valid_in on the same edge.

Structure
REQ-030 SHALL place the key_mode encoding, Nk/Nr lookup functions and the S-box table in shared package aes_pkg.
REQ-031 SHALL instantiate sub-module aes_sbox_word (4 parallel byte S-box lookups, combinational) once.
REQ-032 SHALL hold the word store in a register array of 4*(MAX_ROUNDS+1) words, one write per cycle.

Verification
REQ-033 SHALL check AES-128: key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> valid_out 40 edges after acceptance; rk_addr=10 gives d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
REQ-034 SHALL check AES-192: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> valid_out after 46 edges; nr=12; rk_addr=12 gives e98ba06f 448c773c 8ecc7204 01002202.
REQ-035 SHALL check AES-256: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> valid_out after 52 edges; rk_addr=14 gives fe4890d1 e6188d0b 046df344 706c631e; rk_addr=15 gives 0.
REQ-036 SHALL check reset 20 cycles into an AES-256 expansion -> ready=1, key_valid=0 and rk_data=0 next cycle; a following AES-128 run matches REQ-033.
REQ-037 SHALL check key_mode=11 in IDLE -> err=1 for one cycle and no state change; valid_in held high through EXPAND -> exactly one valid_out, then back-to-back restart per REQ-027.
